// File: rtl/elbeth_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM states, default addresses, redirect record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package elbeth_fetch_ctrl_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0200;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0100;
  localparam logic [31:0] DEF_PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  // A redirect request: exc marks exception class so a later branch cannot displace it.
  typedef struct packed {
    logic        vld;
    logic        exc;
    logic [31:0] pc;
  } redir_t;

  // Sequential PC advance; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/elbeth_fetch_ctrl_if.sv
// Bundle between the fetch controller, the PC register/pipeline and the imem port.
// Latency: n/a (wiring only).
// Backpressure: imem_ready is the memory's accept/return strobe for imem_req.
// Ports: pc, hazard_stall, branch_taken, branch_target, exc_req, imem_ready (into controller);
//        imem_req, next_pc, ctrl_stall, ctrl_flush, fetch_valid (out of controller).
interface elbeth_fetch_ctrl_if;
  logic [31:0] pc;
  logic        hazard_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exc_req;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] next_pc;
  logic        ctrl_stall;
  logic        ctrl_flush;
  logic        fetch_valid;

  // master: the fetch controller itself
  modport master (
    input  pc, hazard_stall, branch_taken, branch_target, exc_req, imem_ready,
    output imem_req, next_pc, ctrl_stall, ctrl_flush, fetch_valid
  );

  // slave: pipeline / memory side that consumes the controls
  modport slave (
    output pc, hazard_stall, branch_taken, branch_target, exc_req, imem_ready,
    input  imem_req, next_pc, ctrl_stall, ctrl_flush, fetch_valid
  );
endinterface

// File: rtl/elbeth_fetch_ctrl_redirect_arb.sv
// Combinational priority merge of a new exception, a new branch and a parked redirect.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is consumed or parked by the caller.
// Ports: i_exc, i_branch, i_branch_target, i_pend (parked redirect) -> o_redir (target + valid + class).
module elbeth_redirect_arb
  import elbeth_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        i_exc,
  input  logic        i_branch,
  input  logic [31:0] i_branch_target,
  input  redir_t      i_pend,
  output redir_t      o_redir
);

  // Exception beats branch; within a class the newest request wins.
  always_comb begin
    o_redir = i_pend;
    if (i_exc) begin
      o_redir = '{vld: 1'b1, exc: 1'b1, pc: EXC_VECTOR};
    end else if (i_branch && !(i_pend.vld && i_pend.exc)) begin
      o_redir = '{vld: 1'b1, exc: 1'b0, pc: i_branch_target};
    end
  end

endmodule

// File: rtl/elbeth_fetch_ctrl.sv
// PC sequencer and imem fetch handshake: picks next_pc, drives stall/flush, parks mid-fetch redirects.
// Latency: next_pc combinational; redirect to first fetch at target is 2 cycles with imem_ready high.
// Backpressure: imem_ready low holds req and stalls the PC; redirects are parked until the fetch retires.
// Ports: clk, rst_n (async, active-low), bus (elbeth_fetch_ctrl_if.master).
// Optional: ELBETH_FETCH_PERF_EN adds perf_stall_cnt / perf_flush_cnt (saturating 32-bit cycle counts).
module elbeth_fetch_ctrl
  import elbeth_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] PC_STEP    = DEF_PC_STEP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elbeth_fetch_ctrl_if.master  bus
`ifdef ELBETH_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  state_t      r_state, w_state_nxt;
  redir_t      r_pend, w_pend_nxt, w_arb;
  logic        w_req, w_stall, w_flush, w_fv;
  logic [31:0] w_npc;

  elbeth_redirect_arb #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
    .i_exc           (bus.exc_req),
    .i_branch        (bus.branch_taken),
    .i_branch_target (bus.branch_target),
    .i_pend          (r_pend),
    .o_redir         (w_arb)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_fv        = 1'b0;
    w_npc       = bus.pc;
    case (r_state)
      S_BOOT: begin
        // PC register resets to RESET_PC itself; hold it for this cycle.
        w_stall     = 1'b1;
        w_npc       = RESET_PC;
        w_state_nxt = S_FETCH;
      end
      S_FETCH, S_WAIT: begin
        // Pending is always empty in S_FETCH, so both states share one decision tree.
        w_req = 1'b1;
        if (!bus.imem_ready) begin
          w_stall     = 1'b1;
          w_pend_nxt  = w_arb;
          w_state_nxt = S_WAIT;
        end else if (w_arb.vld) begin
          // Redirect overrides hazard_stall so the PC actually loads the target.
          w_npc       = w_arb.pc;
          w_flush     = 1'b1;
          w_pend_nxt  = '0;
          // A parked redirect already spent its bubble while waiting.
          w_state_nxt = r_pend.vld ? S_FETCH : S_REDIR;
        end else begin
          w_fv        = 1'b1;
          w_npc       = pc_add(bus.pc, PC_STEP);
          w_stall     = bus.hazard_stall;
          w_state_nxt = S_FETCH;
        end
      end
      S_REDIR: begin
        w_flush     = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Outputs forced low while reset is held, independent of the clock.
  assign bus.imem_req    = w_req   & rst_n;
  assign bus.ctrl_stall  = w_stall & rst_n;
  assign bus.ctrl_flush  = w_flush & rst_n;
  assign bus.fetch_valid = w_fv    & rst_n;
  assign bus.next_pc     = rst_n ? w_npc : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

`ifdef ELBETH_FETCH_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (bus.ctrl_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.ctrl_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
